// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave that frames MOSI into {cmd,payload} RAM words and returns RAM read data on MISO
module spi_slave_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  localparam int CW = $clog2(ADDR_SIZE + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  typedef enum logic [1:0] {SHIFT, WAIT_TX, SEND, HOLD} phase_t;
  state_t               state_q;
  phase_t               ph_q;
  logic [ADDR_SIZE:0]   sh_q;
  logic [ADDR_SIZE-1:0] tx_q;
  logic [CW-1:0]        cnt_q;
  logic                 rd_addr_done_q;
  logic                 miso_q;
  logic [ADDR_SIZE+1:0] rx_data_q;
  logic                 rx_valid_q;
  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  // Frame FSM: command decode, payload shift-in, capture strobe, and MISO read-back phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ph_q           <= SHIFT;
      sh_q           <= '0;
      tx_q           <= '0;
      cnt_q          <= '0;
      rd_addr_done_q <= 1'b0;
      miso_q         <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (!SS_n) state_q <= CHK_CMD;
        CHK_CMD: begin
          if (SS_n) state_q <= IDLE;
          else begin
            sh_q    <= {sh_q[ADDR_SIZE-1:0], MOSI};
            cnt_q   <= CW'(ADDR_SIZE);
            ph_q    <= SHIFT;
            state_q <= !MOSI ? WRITE : rd_addr_done_q ? READ_DATA : READ_ADD;
          end
        end
        default: begin
          if (ph_q == SHIFT) begin
            sh_q  <= {sh_q[ADDR_SIZE-1:0], MOSI};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              rx_data_q  <= {sh_q, MOSI};
              rx_valid_q <= 1'b1;
              ph_q       <= (state_q == READ_DATA) ? WAIT_TX : HOLD;
              if (state_q == READ_ADD) rd_addr_done_q <= 1'b1;
            end
          end else if (!SS_n && ph_q == WAIT_TX && tx_valid) begin
            miso_q <= tx_data[ADDR_SIZE-1];
            tx_q   <= {tx_data[ADDR_SIZE-2:0], 1'b0};
            cnt_q  <= CW'(ADDR_SIZE - 1);
            ph_q   <= SEND;
          end else if (!SS_n && ph_q == SEND) begin
            if (cnt_q == '0) begin
              miso_q         <= 1'b0;
              rd_addr_done_q <= 1'b0;
              ph_q           <= HOLD;
            end else begin
              miso_q <= tx_q[ADDR_SIZE-1];
              tx_q   <= {tx_q[ADDR_SIZE-2:0], 1'b0};
              cnt_q  <= cnt_q - 1'b1;
            end
          end
          if (SS_n) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: scoreboard bench for spi_slave_ctrl with MEM_DEPTH=256 (10-bit frames)
module tb_spi_slave_ctrl;
  logic       clk = 0, rst = 0, SS_n = 1, MOSI = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       MISO, rx_valid;
  logic [9:0] rx_data;
  int         checks = 0, errors = 0, rxv_cnt = 0;
  logic [9:0] rxq[$];
  logic       prev_rxv = 0;

  spi_slave_ctrl #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every rx_valid strobe pops one expected frame
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rxv_cnt++;
      checks++;
      if (rxq.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got rx_data=%h, none expected", rx_data);
      end else begin
        logic [9:0] e;
        e = rxq.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got %h, expected %h", rx_data, e);
        end
      end
      checks++;
      if (prev_rxv) begin
        errors++;
        $display("FAIL rx_valid_width: got high 2 cycles, expected 1");
      end
    end
    prev_rxv = rx_valid;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; SS_n = 1; MOSI = 0; tx_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic drive_frame(input logic [9:0] f, input int nbits, input bit ss_with_last);
    @(negedge clk);
    SS_n = 0; MOSI = 0;
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk);
      checks++;
      if (MISO !== 1'b0) begin
        errors++;
        $display("FAIL miso_in_frame: got %b, expected 0 (bit %0d)", MISO, i);
      end
      MOSI = f[i];
      if (ss_with_last && i == 10 - nbits) SS_n = 1;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    SS_n = 1;
    @(negedge clk);
  endtask

  task automatic check_rxv_delta(input int snap, input int want, input string name);
    checks++;
    if (rxv_cnt - snap !== want) begin
      errors++;
      $display("FAIL %s: got %0d rx_valid pulses, expected %0d", name, rxv_cnt - snap, want);
    end
  endtask

  // Frame must take the READ_ADD path: strobe, and tx_valid produces no MISO
  task automatic expect_no_miso(input logic [9:0] f, input string name);
    int snap;
    snap = rxv_cnt;
    rxq.push_back(f);
    drive_frame(f, 10, 0);
    @(negedge clk);
    tx_data = 8'hFF; tx_valid = 1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (MISO !== 1'b0) begin
        errors++;
        $display("FAIL %s: got MISO=%b, expected 0", name, MISO);
      end
    end
    tx_valid = 0;
    end_frame();
    check_rxv_delta(snap, 1, name);
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    checks += 3;
    if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, expected 0", MISO); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b, expected 0", rx_valid); end
    if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h, expected 000", rx_data); end
    apply_reset();
  endtask

  task automatic test_write_addr();
    int snap;
    snap = rxv_cnt;
    rxq.push_back(10'h0A5);
    drive_frame(10'h0A5, 10, 0);
    end_frame();
    repeat (3) @(negedge clk);
    check_rxv_delta(snap, 1, "write_addr_pulses");
  endtask

  task automatic test_read_no_addr();
    expect_no_miso(10'h301, "read_no_addr");
  endtask

  task automatic test_read_seq();
    logic mq[$];
    logic e;
    apply_reset();
    rxq.push_back(10'h23C);
    drive_frame(10'h23C, 10, 0);
    end_frame();
    rxq.push_back(10'h3AA);
    drive_frame(10'h3AA, 10, 0);
    @(negedge clk);
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL read_wait_miso: got %b, expected 0", MISO); end
    tx_data = 8'hC3; tx_valid = 1;
    for (int i = 7; i >= 0; i--) mq.push_back(tx_data[i]);
    mq.push_back(1'b0);
    mq.push_back(1'b0);
    @(negedge clk);
    tx_valid = 0;
    for (int k = 0; mq.size() > 0; k++) begin
      e = mq.pop_front();
      checks++;
      if (MISO !== e) begin
        errors++;
        $display("FAIL read_miso_bit%0d: got %b, expected %b", k, MISO, e);
      end
      @(negedge clk);
    end
    end_frame();
    expect_no_miso(10'h355, "rd_done_cleared");
  endtask

  task automatic test_abort();
    int snap;
    apply_reset();
    snap = rxv_cnt;
    drive_frame(10'h0A5, 5, 0);
    end_frame();
    repeat (12) @(negedge clk);
    check_rxv_delta(snap, 0, "abort_no_rx");
    snap = rxv_cnt;
    rxq.push_back(10'h15A);
    drive_frame(10'h15A, 10, 0);
    end_frame();
    check_rxv_delta(snap, 1, "abort_next_frame");
  endtask

  task automatic test_reset_mid_miso();
    apply_reset();
    rxq.push_back(10'h2F0);
    drive_frame(10'h2F0, 10, 0);
    end_frame();
    rxq.push_back(10'h300);
    drive_frame(10'h300, 10, 0);
    @(negedge clk);
    tx_data = 8'hFF; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (MISO !== 1'b1) begin errors++; $display("FAIL mid_miso_pre: got %b, expected 1", MISO); end
    #2 rst = 1;
    #1;
    checks += 3;
    if (MISO !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b, expected 0", MISO); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rxv: got %b, expected 0", rx_valid); end
    if (rx_data !== 10'h000) begin errors++; $display("FAIL rst_mid_rxdata: got %h, expected 000", rx_data); end
    @(negedge clk);
    SS_n = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    expect_no_miso(10'h3C1, "rst_clears_rd_done");
  endtask

  task automatic test_stray_tx();
    int snap;
    snap = rxv_cnt;
    tx_data = 8'hFF; tx_valid = 1;
    rxq.push_back(10'h1F0);
    drive_frame(10'h1F0, 10, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (MISO !== 1'b0) begin errors++; $display("FAIL stray_tx_miso: got %b, expected 0", MISO); end
    end
    tx_valid = 0;
    end_frame();
    check_rxv_delta(snap, 1, "stray_tx_pulses");
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr[4];
    int snap;
    fr = '{10'h012, 10'h1FF, 10'h080, 10'h0FE};
    snap = rxv_cnt;
    foreach (fr[i]) begin
      rxq.push_back(fr[i]);
      drive_frame(fr[i], 10, 1);
    end
    @(negedge clk);
    @(negedge clk);
    check_rxv_delta(snap, 4, "back_to_back_pulses");
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_no_addr();
    test_read_seq();
    test_abort();
    test_reset_mid_miso();
    test_stray_tx();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (rxq.size() !== 0) begin
      errors++;
      $display("FAIL rx_missing: got %0d frames never strobed, expected 0", rxq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Serial-to-parallel SPI slave controller that sits between the external SPI master pins and the single-port RAM. It converts MOSI frames into `{cmd, payload}` words on the RAM-side `rx_data`/`rx_valid` port. For read-data commands it waits for the RAM's `tx_data`/`tx_valid` reply and serialises it back out on MISO. It drives the same slave↔RAM interface that the RAM consumes, from the opposite end.

## Interface
- `MEM_DEPTH`, default 256: RAM depth. `ADDR_SIZE = $clog2(MEM_DEPTH)` is derived and also sets the data width.
- `clk` in 1: single clock; the SPI bit clock and the system clock are the same; all sampling is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `SS_n` in 1: slave select, active-low; frames the transfer.
- `MOSI` in 1: serial data in, MSB first.
- `MISO` out 1: serial data out, MSB first.
- `rx_data` out ADDR_SIZE+2: captured frame. Bits [ADDR_SIZE+1:ADDR_SIZE] are the command (00 write-addr, 01 write-data, 10 read-addr, 11 read-data); the remaining bits are the payload.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data` in ADDR_SIZE: read data returned by the RAM.
- `tx_valid` in 1: the RAM read data is valid.

## Operation
- **States:** IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- **Internal flag `rd_addr_done`:** reset 0. It is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes its MISO phase.
- **IDLE:** `SS_n`=0 → CHK_CMD; otherwise stay in IDLE.
- **CHK_CMD:** `SS_n`=1 → IDLE. Otherwise sample MOSI as frame bit ADDR_SIZE+1:
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_done`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_done`=1 → READ_DATA.
- **WRITE / READ_ADD / READ_DATA:** shift MOSI into the shift register, MSB first, for the remaining ADDR_SIZE+1 bits, tracked by a bit counter.
  - On the edge that captures bit 0, load `rx_data` with the full ADDR_SIZE+2-bit shift value and assert `rx_valid` for exactly one cycle.
  - `rx_data` carries the shifted bits verbatim. The state choice does not alter the command bits.
- **WRITE, READ_ADD after the capture:** hold the state and ignore further MOSI bits until `SS_n`=1 → IDLE.
- **READ_DATA after the capture:**
  - Wait for `tx_valid`=1, then latch `tx_data`.
  - Starting on the next edge, drive MISO = `tx_data[ADDR_SIZE-1]` down to `[0]`, one bit per cycle, ADDR_SIZE cycles total.
  - Then set MISO=0, clear `rd_addr_done`, and hold until `SS_n`=1.
- **`tx_valid` outside the READ_DATA wait window:** ignored.
- **`SS_n`=1 mid-frame, from any non-IDLE state:** return to IDLE on that edge. Partial bits are discarded, no `rx_valid` is produced, MISO goes to 0, and `rd_addr_done` is unchanged unless its set/clear condition already occurred.
- **`SS_n` rising on the same edge as bit 0 capture:** the capture completes (`rx_valid` pulses) and the next state is IDLE.

## Timing
- **Reset values:** state IDLE, `rx_data`=0, `rx_valid`=0, MISO=0, `rd_addr_done`=0, counter 0.
- **Reset mid-transfer:** takes effect immediately (asynchronous); any MISO shifting is aborted.
- **Frame length:** ADDR_SIZE+2 bits. With `SS_n` sampled low at edge E0:
  - E1: bit ADDR_SIZE+1 captured (CHK_CMD).
  - E2 … E(ADDR_SIZE+2): remaining bits captured.
  - `rx_valid` is high from E(ADDR_SIZE+2) to E(ADDR_SIZE+3).
- **Read return:** with `tx_valid` sampled at edge T, MISO carries the MSB after T and the LSB after T+ADDR_SIZE−1; MISO=0 after T+ADDR_SIZE.
- **Back-to-back frames:** `SS_n` high for at least 1 cycle between frames.

## Test plan
All scenarios use MEM_DEPTH=256, so ADDR_SIZE=8 and frames are 10 bits.
- **Write-address frame:** `SS_n`=0, MOSI `00_1010_0101` → `rx_data`=10'h0A5, `rx_valid` high for exactly 1 cycle; MISO stays 0.
- **Read-address then read-data:**
  - Frame 1, MOSI `10_0011_1100` → `rx_data`=10'h23C, next state READ_ADD, `rd_addr_done`=1.
  - Frame 2, MOSI `11_xxxx_xxxx` → state READ_DATA.
  - RAM returns `tx_data`=8'hC3 with `tx_valid` → MISO sequence 1,1,0,0,0,0,1,1, then 0; `rd_addr_done`=0.
- **Read-data command with no prior read-address:** MOSI `11_0000_0001` from reset → takes the READ_ADD path; `rx_data`=10'h301, `rx_valid` pulses, no MISO output even if `tx_valid`=1.
- **Abort:** `SS_n` raised after 5 bits → no `rx_valid`, state IDLE. The next full frame decodes correctly.
- **Reset mid-MISO:** assert `rst` during bit 3 of the MISO phase → MISO=0, `rx_valid`=0, state IDLE, `rd_addr_done`=0 immediately.
- **Stray `tx_valid` during a WRITE frame:** `tx_valid`=1 with `tx_data`=8'hFF → ignored; MISO stays 0 and the write capture is unaffected.
